// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: stall bus, load-type codes, HI/LO enable bits
// and the MEM pipeline-register layout.
package mem_stage_pkg;

  localparam int STALL_W   = 6;
  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  typedef logic [STALL_W-1:0] StallBus;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  localparam int HILO_HI = 1;
  localparam int HILO_LO = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [2:0]  load_type;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
    logic [1:0]  hilo_we;
    logic [63:0] hilo_wdata;
    logic [1:0]  hilo_rd;
  } mem_reg_t;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX-to-MEM bundle, SRAM read response and MEM outputs (write-back, forwarding, HI/LO).
interface mem_stage_if;
  logic [31:0] ex_pc;
  logic        ex_data_ram_en;
  logic [3:0]  ex_data_ram_wen;
  logic [2:0]  ex_load_type;
  logic        ex_sel_rf_res;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_result;
  logic [1:0]  ex_hilo_we;
  logic [63:0] ex_hilo_wdata;
  logic [1:0]  ex_hilo_rd;
  logic [31:0] data_sram_rdata;

  logic [31:0] mem_pc;
  logic        mem_rf_we;
  logic [4:0]  mem_rf_waddr;
  logic [31:0] mem_rf_wdata;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_waddr;
  logic [31:0] mem_fwd_wdata;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output ex_pc, ex_data_ram_en, ex_data_ram_wen, ex_load_type, ex_sel_rf_res,
           ex_rf_we, ex_rf_waddr, ex_result, ex_hilo_we, ex_hilo_wdata, ex_hilo_rd,
           data_sram_rdata,
    input  mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
           mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata, hi_o, lo_o
  );

  modport slave (
    input  ex_pc, ex_data_ram_en, ex_data_ram_wen, ex_load_type, ex_sel_rf_res,
           ex_rf_we, ex_rf_waddr, ex_result, ex_hilo_we, ex_hilo_wdata, ex_hilo_rd,
           data_sram_rdata,
    output mem_pc, mem_rf_we, mem_rf_waddr, mem_rf_wdata,
           mem_fwd_we, mem_fwd_waddr, mem_fwd_wdata, hi_o, lo_o
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load-data alignment: picks the addressed byte/halfword of the SRAM word and extends it.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_load_type,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte/halfword lane select; halfword ignores addr[0]
  always_comb begin
    w_byte = 8'h00;
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr[1]) w_half = i_rdata[31:16];
    else           w_half = i_rdata[15:0];
  end

  // Extension by load type; unknown codes behave as lw
  always_comb begin
    o_data = i_rdata;
    case (i_load_type)
      LD_LB:   o_data = ext8(w_byte, 1'b1);
      LD_LBU:  o_data = ext8(w_byte, 1'b0);
      LD_LH:   o_data = ext16(w_half, 1'b1);
      LD_LHU:  o_data = ext16(w_half, 1'b0);
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX result register, stalled-load read buffer, load alignment, HI/LO.
// Optional feature macro MEM_HILO_EN adds the HI/LO registers and the mfhi/mflo mux.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  StallBus    stall,
  mem_stage_if.slave bus
);

  mem_reg_t    w_ex;
  mem_reg_t    r_mem;
  logic        r_first;
  logic [31:0] r_rbuf;
  logic [31:0] w_rdata;
  logic [31:0] w_load_data;
  logic [31:0] w_wdata;
  logic        w_unused_stall;

  assign w_unused_stall = ^{stall[5], stall[2:0], r_mem.ram_en, r_mem.ram_wen};

  // Gather the EX bundle; HI/LO fields stay zero when the feature is absent
  always_comb begin
    w_ex            = '0;
    w_ex.pc         = bus.ex_pc;
    w_ex.ram_en     = bus.ex_data_ram_en;
    w_ex.ram_wen    = bus.ex_data_ram_wen;
    w_ex.load_type  = bus.ex_load_type;
    w_ex.sel_rf_res = bus.ex_sel_rf_res;
    w_ex.rf_we      = bus.ex_rf_we;
    w_ex.rf_waddr   = bus.ex_rf_waddr;
    w_ex.result     = bus.ex_result;
`ifdef MEM_HILO_EN
    w_ex.hilo_we    = bus.ex_hilo_we;
    w_ex.hilo_wdata = bus.ex_hilo_wdata;
    w_ex.hilo_rd    = bus.ex_hilo_rd;
`endif
  end

  // MEM input register: load, insert bubble, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem   <= '0;
      r_first <= 1'b0;
    end else if (stall[STALL_MEM] == NoStop) begin
      r_mem   <= w_ex;
      r_first <= 1'b1;
    end else if (stall[STALL_WB] == NoStop) begin
      r_mem   <= '0;
      r_first <= 1'b0;
    end else begin
      r_mem   <= r_mem;
      r_first <= 1'b0;
    end
  end

  // SRAM data is only valid for one cycle, so keep it while the load is held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rbuf <= 32'h0;
    end else if (r_first && (stall[STALL_MEM] == Stop)) begin
      r_rbuf <= bus.data_sram_rdata;
    end else begin
      r_rbuf <= r_rbuf;
    end
  end

  assign w_rdata = r_first ? bus.data_sram_rdata : r_rbuf;

  mem_stage_load_align u_load_align (
    .i_rdata     (w_rdata),
    .i_addr      (r_mem.result[1:0]),
    .i_load_type (r_mem.load_type),
    .o_data      (w_load_data)
  );

`ifdef MEM_HILO_EN
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // HI/LO commit as the instruction leaves MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= 32'h0;
      r_lo <= 32'h0;
    end else if (stall[STALL_WB] == NoStop) begin
      if (r_mem.hilo_we[HILO_HI]) r_hi <= r_mem.hilo_wdata[63:32];
      else                        r_hi <= r_hi;
      if (r_mem.hilo_we[HILO_LO]) r_lo <= r_mem.hilo_wdata[31:0];
      else                        r_lo <= r_lo;
    end else begin
      r_hi <= r_hi;
      r_lo <= r_lo;
    end
  end

  // Write-back source, first match wins
  always_comb begin
    w_wdata = r_mem.result;
    if (r_mem.sel_rf_res)                w_wdata = w_load_data;
    else if (r_mem.hilo_rd[HILO_HI])     w_wdata = r_hi;
    else if (r_mem.hilo_rd[HILO_LO])     w_wdata = r_lo;
    else                                 w_wdata = r_mem.result;
  end

  assign bus.hi_o = r_hi;
  assign bus.lo_o = r_lo;
`else
  logic w_unused_hilo;
  assign w_unused_hilo = ^{bus.ex_hilo_we, bus.ex_hilo_wdata, bus.ex_hilo_rd,
                           r_mem.hilo_we, r_mem.hilo_wdata, r_mem.hilo_rd};

  // Write-back source: load data or ALU result
  always_comb begin
    w_wdata = r_mem.result;
    if (r_mem.sel_rf_res) w_wdata = w_load_data;
    else                  w_wdata = r_mem.result;
  end

  assign bus.hi_o = 32'h0;
  assign bus.lo_o = 32'h0;
`endif

  assign bus.mem_pc        = r_mem.pc;
  assign bus.mem_rf_we     = r_mem.rf_we;
  assign bus.mem_rf_waddr  = r_mem.rf_waddr;
  assign bus.mem_rf_wdata  = w_wdata;
  assign bus.mem_fwd_we    = r_mem.rf_we;
  assign bus.mem_fwd_waddr = r_mem.rf_waddr;
  assign bus.mem_fwd_wdata = w_wdata;

endmodule
